// File: rtl/cpu_dmem_responder_pkg.sv
// Shared types and helpers for the CPU data-bus responder: FSM states,
// access sizes, address regions and read-data lane alignment.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAM_RESP,
        PER_ISSUE,
        PER_WAIT,
        RESP
    } dmem_state_t;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_PER,
        REGION_NONE
    } region_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Right-align and zero-extend the addressed lane; bit 0 of the lane is
    // ignored for halves, and the illegal size yields zero.
    function automatic logic [31:0] align_rdata(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size);
        case (size)
            SIZE_BYTE: align_rdata = {24'b0, word[8*lane +: 8]};
            SIZE_HALF: align_rdata = {16'b0, word[16*lane[1] +: 16]};
            SIZE_WORD: align_rdata = word;
            default:   align_rdata = '0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_dmem_responder_if.sv
// CPU data bus plus the peripheral-side bus of the responder; the responder
// uses the slave view, the CPU/fabric side uses the master view.
interface cpu_dmem_responder_if;
    logic        cpud_request;
    logic [31:0] cpud_addr;
    logic        cpud_write;
    logic [3:0]  cpud_byte_enable;
    logic [31:0] cpud_wdata;
    logic [1:0]  cpud_size;
    logic        cpud_ack;
    logic [31:0] cpud_rdata;
    logic        cpud_error;
    logic        cpud_busy;
    logic        per_request;
    logic [23:0] per_addr;
    logic        per_write;
    logic [3:0]  per_byte_enable;
    logic [31:0] per_wdata;
    logic [31:0] per_rdata;
    logic        per_ack;

    modport slave (
        input  cpud_request, cpud_addr, cpud_write, cpud_byte_enable, cpud_wdata, cpud_size,
        output cpud_ack, cpud_rdata, cpud_error, cpud_busy,
        output per_request, per_addr, per_write, per_byte_enable, per_wdata,
        input  per_rdata, per_ack
    );

    modport master (
        output cpud_request, cpud_addr, cpud_write, cpud_byte_enable, cpud_wdata, cpud_size,
        input  cpud_ack, cpud_rdata, cpud_error, cpud_busy,
        input  per_request, per_addr, per_write, per_byte_enable, per_wdata,
        output per_rdata, per_ack
    );
endinterface

// File: rtl/cpu_dmem_responder_ram.sv
// Synchronous single-port data RAM with per-byte write enables; no reset so
// it maps onto block RAM.
module dmem_ram #(
    parameter int WORDS = 16384,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clock,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [WORDS];

    always_ff @(posedge clock) begin
        if (en) begin
            for (int b = 0; b < 4; b++)
                if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/cpu_dmem_responder.sv
// CPU data-bus responder: services requests from on-chip RAM or forwards them
// to the peripheral bus. Define DMEM_TIMEOUT_EN to build the per_ack timeout.
module cpu_dmem_responder
    import cpu_bus_pkg::*;
#(
    parameter int         RAM_WORDS = 16384,
    parameter logic [7:0] PER_BASE  = 8'hE0,
    parameter int         TIMEOUT   = 255
) (
    input logic                 clock,
    input logic                 reset,
    cpu_dmem_responder_if.slave bus
);
    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;
    localparam logic [7:0]  TO_LIM    = 8'(TIMEOUT);

    dmem_state_t state, state_nx;
    region_t     region;
    logic        accept, bad_size, ram_en, timed_out;
    logic [3:0]  ram_we;
    logic [31:0] ram_q, per_q;
    logic [23:0] cap_addr;
    logic        cap_write, cap_err;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic [1:0]  cap_size;
    logic        ack, err, per_req;
    logic [31:0] rdata;

    always_comb begin
        region = REGION_NONE;
        if ({1'b0, bus.cpud_addr} < RAM_BYTES)   region = REGION_RAM;
        else if (bus.cpud_addr[31:24] == PER_BASE) region = REGION_PER;
    end

    assign bad_size = (bus.cpud_size == 2'b11);
    assign accept   = (state == IDLE) && bus.cpud_request;
    // RAM is launched in the request cycle so data is ready one cycle later
    assign ram_en   = accept && (region == REGION_RAM) && !bad_size;
    assign ram_we   = (ram_en && bus.cpud_write) ? bus.cpud_byte_enable : 4'b0;

    dmem_ram #(.WORDS(RAM_WORDS), .AW(AW)) u_ram (
        .clock (clock),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (bus.cpud_addr[AW+1:2]),
        .wdata (bus.cpud_wdata),
        .rdata (ram_q)
    );

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                  wait_cnt <= '0;
        else if (state == PER_ISSUE) wait_cnt <= '0;
        else if (state == PER_WAIT)  wait_cnt <= wait_cnt + 8'd1;
    end

    assign timed_out = (state == PER_WAIT) && (wait_cnt == TO_LIM);
`else
    logic unused_timeout;
    assign unused_timeout = ^TO_LIM;
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_be    <= '0;
            cap_wdata <= '0;
            cap_size  <= '0;
            cap_err   <= 1'b0;
            per_q     <= '0;
        end else if (accept) begin
            cap_addr  <= bus.cpud_addr[23:0];
            cap_write <= bus.cpud_write;
            cap_be    <= bus.cpud_byte_enable;
            cap_wdata <= bus.cpud_wdata;
            cap_size  <= bus.cpud_size;
            cap_err   <= bad_size || (region == REGION_NONE);
        end else if (state == PER_WAIT) begin
            // per_ack beats a timeout landing in the same cycle
            if (bus.per_ack)     per_q   <= bus.per_rdata;
            else if (timed_out)  cap_err <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        ack      = 1'b0;
        err      = 1'b0;
        per_req  = 1'b0;
        rdata    = '0;
        case (state)
            IDLE: begin
                if (bus.cpud_request) begin
                    if (bad_size || region == REGION_NONE) state_nx = RESP;
                    else if (region == REGION_RAM)         state_nx = RAM_RESP;
                    else                                   state_nx = PER_ISSUE;
                end
            end
            RAM_RESP: begin
                ack      = 1'b1;
                rdata    = cap_write ? '0 : align_rdata(ram_q, cap_addr[1:0], cap_size);
                state_nx = IDLE;
            end
            PER_ISSUE: begin
                per_req  = 1'b1;
                state_nx = PER_WAIT;
            end
            PER_WAIT: begin
                if (bus.per_ack || timed_out) state_nx = RESP;
            end
            RESP: begin
                ack      = 1'b1;
                err      = cap_err;
                rdata    = (cap_err || cap_write) ? '0 : align_rdata(per_q, cap_addr[1:0], cap_size);
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.cpud_ack        = ack;
    assign bus.cpud_error      = err;
    assign bus.cpud_rdata      = rdata;
    assign bus.cpud_busy       = (state != IDLE);
    assign bus.per_request     = per_req;
    assign bus.per_addr        = cap_addr;
    assign bus.per_write       = cap_write;
    assign bus.per_byte_enable = cap_be;
    assign bus.per_wdata       = cap_wdata;

endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Randomized self-checking bench for cpu_dmem_responder against a byte-level
// memory model; the timeout scenario is built when DMEM_TIMEOUT_EN is defined.
module tb_cpu_dmem_responder;
    localparam int RAM_WORDS = 1024;
    localparam int RAM_BYTES = RAM_WORDS * 4;
    localparam int TIMEOUT   = 8;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] mdl [RAM_BYTES];

    always #5 clock = ~clock;

    cpu_dmem_responder_if bus();

    cpu_dmem_responder #(
        .RAM_WORDS (RAM_WORDS),
        .PER_BASE  (8'hE0),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [31:0] word, input logic [31:0] a,
                                         input logic [1:0] sz);
        case (sz)
            2'd0:    return (word >> (8 * (a % 4))) & 32'hFF;
            2'd1:    return (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            2'd2:    return word;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mdl_word(input logic [31:0] a);
        int base;
        base = int'(a) & ~3;
        return {mdl[base+3], mdl[base+2], mdl[base+1], mdl[base]};
    endfunction

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] be,
                         input logic [31:0] wd, input logic [1:0] sz);
        bus.cpud_request     = 1'b1;
        bus.cpud_addr        = a;
        bus.cpud_write       = w;
        bus.cpud_byte_enable = be;
        bus.cpud_wdata       = wd;
        bus.cpud_size        = sz;
        cycle();
        bus.cpud_request     = 1'b0;
    endtask

    // RAM or unmapped access: completes in the cycle after the request
    task automatic ram_op(input logic [31:0] a, input logic w, input logic [3:0] be,
                          input logic [31:0] wd, input logic [1:0] sz);
        logic        exp_err;
        logic [31:0] exp_rd;
        exp_err = (sz == 2'd3) || (a >= RAM_BYTES);
        exp_rd  = 32'h0;
        if (!exp_err) begin
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[(int'(a) & ~3) + b] = wd[8*b +: 8];
            end else begin
                exp_rd = pick(mdl_word(a), a, sz);
            end
        end
        issue(a, w, be, wd, sz);
        chk("ram_ack", bus.cpud_ack, 1'b1);
        chk("ram_err", bus.cpud_error, exp_err);
        chk("ram_no_preq", bus.per_request, 1'b0);
        if (!w || exp_err) chk("ram_rdata", bus.cpud_rdata, exp_rd);
        cycle();
        chk("ram_ack_end", bus.cpud_ack, 1'b0);
        chk("ram_busy_end", bus.cpud_busy, 1'b0);
        chk("ram_rdata_idle", bus.cpud_rdata, 32'h0);
    endtask

    // Peripheral access acked dly cycles after per_request
    task automatic per_op(input logic [31:0] a, input logic w, input logic [3:0] be,
                          input logic [31:0] wd, input logic [1:0] sz, input int dly,
                          input logic [31:0] rd);
        issue(a, w, be, wd, sz);
        chk("per_req", bus.per_request, 1'b1);
        chk("per_addr", {8'h0, bus.per_addr}, {8'h0, a[23:0]});
        chk("per_write", bus.per_write, w);
        chk("per_be", {28'h0, bus.per_byte_enable}, {28'h0, be});
        if (w) chk("per_wdata", bus.per_wdata, wd);
        chk("per_ack_early", bus.cpud_ack, 1'b0);
        repeat (dly) begin
            cycle();
            chk("per_wait_ack", bus.cpud_ack, 1'b0);
            chk("per_req_once", bus.per_request, 1'b0);
        end
        bus.per_ack   = 1'b1;
        bus.per_rdata = rd;
        cycle();
        bus.per_ack   = 1'b0;
        bus.per_rdata = $urandom;
        chk("per_cack", bus.cpud_ack, 1'b1);
        chk("per_err", bus.cpud_error, 1'b0);
        if (!w) chk("per_rdata", bus.cpud_rdata, pick(rd, a, sz));
        cycle();
        chk("per_ack_end", bus.cpud_ack, 1'b0);
        chk("per_busy_end", bus.cpud_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] a, wd, rd;
        logic [3:0]  be;
        logic [1:0]  sz;
        logic        w;
        int          idx, kind;

        reset = 1'b1;
        bus.cpud_request = 1'b0;  bus.cpud_addr = '0;  bus.cpud_write = 1'b0;
        bus.cpud_byte_enable = '0; bus.cpud_wdata = '0; bus.cpud_size = '0;
        bus.per_rdata = '0;       bus.per_ack = 1'b0;
        #2;
        chk("rst_ack", bus.cpud_ack, 1'b0);
        chk("rst_err", bus.cpud_error, 1'b0);
        chk("rst_busy", bus.cpud_busy, 1'b0);
        chk("rst_rdata", bus.cpud_rdata, 32'h0);
        chk("rst_preq", bus.per_request, 1'b0);
        chk("rst_pwrite", bus.per_write, 1'b0);
        chk("rst_pbe", {28'h0, bus.per_byte_enable}, 32'h0);
        chk("rst_paddr", {8'h0, bus.per_addr}, 32'h0);
        chk("rst_pwdata", bus.per_wdata, 32'h0);
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Directed: word write/read, byte-lane merge, lane extraction
        ram_op(32'h100, 1'b1, 4'hF, 32'hDEADBEEF, 2'd2);
        ram_op(32'h100, 1'b0, 4'h0, 32'h0, 2'd2);
        ram_op(32'h103, 1'b1, 4'b1000, {8'hAB, 24'($urandom)}, 2'd0);
        ram_op(32'h103, 1'b0, 4'h0, 32'h0, 2'd0);
        ram_op(32'h102, 1'b0, 4'h0, 32'h0, 2'd1);
        ram_op(32'h100, 1'b1, 4'h0, 32'h12345678, 2'd2);
        ram_op(32'h100, 1'b0, 4'h0, 32'h0, 2'd2);

        // Preload words 0..63 and the last RAM word so every read is defined
        for (int i = 0; i < 64; i++) ram_op(32'(i * 4), 1'b1, 4'hF, $urandom, 2'd2);
        ram_op(32'(RAM_BYTES - 4), 1'b1, 4'hF, $urandom, 2'd2);
        ram_op(32'(RAM_BYTES - 1), 1'b0, 4'h0, 32'h0, 2'd0);
        ram_op(32'(RAM_BYTES), 1'b0, 4'h0, 32'h0, 2'd2);
        ram_op(32'h0000_0040, 1'b1, 4'hF, 32'hFFFF_FFFF, 2'd3);
        ram_op(32'h0000_0040, 1'b0, 4'h0, 32'h0, 2'd2);

        per_op(32'hE000_0010, 1'b0, 4'hF, 32'h0, 2'd2, 4, 32'h12345678);
        per_op(32'hE000_0022, 1'b0, 4'hF, 32'h0, 2'd1, 1, 32'hCAFEF00D);
        per_op(32'hE012_3454, 1'b1, 4'b0110, 32'h00BEEF00, 2'd1, TIMEOUT + 1, 32'h0);

        // Unmapped read, then a second request while busy must be dropped
        issue(32'h4000_0000, 1'b0, 4'h0, 32'h0, 2'd2);
        chk("unmap_ack", bus.cpud_ack, 1'b1);
        chk("unmap_err", bus.cpud_error, 1'b1);
        chk("unmap_rdata", bus.cpud_rdata, 32'h0);
        chk("unmap_busy", bus.cpud_busy, 1'b1);
        bus.cpud_request = 1'b1;
        bus.cpud_addr    = 32'h100;
        bus.cpud_write   = 1'b0;
        bus.cpud_size    = 2'd2;
        cycle();
        bus.cpud_request = 1'b0;
        chk("drop_ack", bus.cpud_ack, 1'b0);
        chk("drop_busy", bus.cpud_busy, 1'b0);
        cycle();
        chk("drop_ack2", bus.cpud_ack, 1'b0);

`ifdef DMEM_TIMEOUT_EN
        // Never-acked peripheral write: error ack at N+2+TIMEOUT+1
        issue(32'hE000_0100, 1'b1, 4'hF, 32'h5555AAAA, 2'd2);
        chk("to_preq", bus.per_request, 1'b1);
        repeat (TIMEOUT + 1) begin
            cycle();
            chk("to_wait_ack", bus.cpud_ack, 1'b0);
        end
        cycle();
        chk("to_ack", bus.cpud_ack, 1'b1);
        chk("to_err", bus.cpud_error, 1'b1);
        chk("to_rdata", bus.cpud_rdata, 32'h0);
        cycle();
        chk("to_ack_end", bus.cpud_ack, 1'b0);
        chk("to_busy_end", bus.cpud_busy, 1'b0);
`else
        // Without the timeout the responder waits for per_ack indefinitely
        issue(32'hE000_0100, 1'b1, 4'hF, 32'h5555AAAA, 2'd2);
        repeat (3 * TIMEOUT) begin
            cycle();
            chk("nto_wait_ack", bus.cpud_ack, 1'b0);
            chk("nto_busy", bus.cpud_busy, 1'b1);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
`endif

        // Reset during PER_WAIT aborts without an ack
        issue(32'hE000_0020, 1'b0, 4'hF, 32'h0, 2'd2);
        cycle();
        cycle();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", bus.cpud_busy, 1'b0);
        chk("rst_mid_ack", bus.cpud_ack, 1'b0);
        cycle();
        reset = 1'b0;
        bus.per_ack   = 1'b1;
        bus.per_rdata = 32'h9999_9999;
        cycle();
        bus.per_ack = 1'b0;
        chk("stale_pack_ack", bus.cpud_ack, 1'b0);
        chk("stale_pack_busy", bus.cpud_busy, 1'b0);
        repeat (3) begin
            cycle();
            chk("post_rst_ack", bus.cpud_ack, 1'b0);
        end
        ram_op(32'h100, 1'b0, 4'h0, 32'h0, 2'd2);

        // Randomized mix of RAM, unmapped and peripheral traffic
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            sz   = 2'($urandom_range(0, 2));
            w    = 1'($urandom_range(0, 1));
            be   = 4'($urandom);
            wd   = $urandom;
            if (kind <= 5) begin
                idx = $urandom_range(0, 64);
                if (idx == 64) idx = RAM_WORDS - 1;
                a = 32'(idx * 4);
                if (sz == 2'd0)      a = a + 32'($urandom_range(0, 3));
                else if (sz == 2'd1) a = a + 32'(2 * $urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) sz = 2'd3;
                ram_op(a, w, be, wd, sz);
            end else if (kind == 6) begin
                a = {8'($urandom_range(1, 8'hDF)), 24'($urandom)};
                if ($urandom_range(0, 3) == 0) a = 32'(RAM_BYTES);
                ram_op(a, w, be, wd, sz);
            end else begin
                a = {8'hE0, 24'($urandom)};
                if (sz == 2'd2)      a[1:0] = 2'b00;
                else if (sz == 2'd1) a[0]   = 1'b0;
                rd = $urandom;
                per_op(a, w, be, wd, sz, $urandom_range(1, TIMEOUT + 1), rd);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
